// File: rtl/circ_queue_if.sv
// rtl/circ_queue_if.sv - push/pop handshake and status bundle for circ_queue (almost flags with CIRC_QUEUE_ALMOST_EN)
interface circ_queue_if #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             push;
    logic [DW-1:0]    push_data;
    logic             pop;
    logic [DW-1:0]    pop_data;
    logic [AW:0]      size;
    logic [AW-1:0]    front;
    logic [DEPTH-1:0] valid;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             udf;
`ifdef CIRC_QUEUE_ALMOST_EN
    logic             almost_full;
    logic             almost_empty;
`endif

`ifdef CIRC_QUEUE_ALMOST_EN
    modport master (
        output push, push_data, pop,
        input  pop_data, size, front, valid, full, empty, ovf, udf,
        input  almost_full, almost_empty
    );

    modport slave (
        input  push, push_data, pop,
        output pop_data, size, front, valid, full, empty, ovf, udf,
        output almost_full, almost_empty
    );
`else
    modport master (
        output push, push_data, pop,
        input  pop_data, size, front, valid, full, empty, ovf, udf
    );

    modport slave (
        input  push, push_data, pop,
        output pop_data, size, front, valid, full, empty, ovf, udf
    );
`endif
endinterface

// File: rtl/circ_queue.sv
// rtl/circ_queue.sv - DEPTH-slot circular data queue with occupancy bitmap; optional almost flags via CIRC_QUEUE_ALMOST_EN
module circ_queue #(
    parameter int DEPTH    = 16,
    parameter int DW       = 8,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic       clk,
    input  logic       rst,
    circ_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);

    // Ring pointers only work with wrapping AW-bit arithmetic, so DEPTH must be 2^AW.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("circ_queue: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH || AF_LEVEL < 0 || AE_LEVEL < 0) begin : g_bad_levels
        $error("circ_queue: AF_LEVEL/AE_LEVEL must lie in 0..DEPTH");
    end

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW:0]   size_q,  size_d;
    logic [AW-1:0] front_q, front_d;
    logic          ovf_q,   ovf_d;
    logic          udf_q,   udf_d;

    logic          pop_ok;
    logic          push_ok;
    logic [AW-1:0] tail;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          is_full;
    logic          is_empty;
    logic [DEPTH-1:0] valid_map;

    // Status derived purely from the registered occupancy.
    always_comb begin
        is_full  = (size_q == (AW+1)'(DEPTH));
        is_empty = (size_q == '0);
        tail     = front_q + size_q[AW-1:0];
    end

    // Accept/reject decisions and next-state for pointers, count and pulses.
    always_comb begin
        pop_ok  = q.pop && !is_empty;
        // A full queue can still take a push when the head leaves in the same cycle.
        push_ok = q.push && (!is_full || pop_ok);

        front_d = front_q;
        size_d  = size_q;
        if (pop_ok) begin
            front_d = front_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            size_d = size_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            size_d = size_q - (AW+1)'(1);
        end

        ovf_d   = q.push && !push_ok;
        udf_d   = q.pop  && !pop_ok;

        wr_en   = push_ok;
        wr_addr = tail;
        wr_data = q.push_data;
    end

    // Control state; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q  <= '0;
            front_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            size_q  <= size_d;
            front_q <= front_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Entry storage; contents are meaningless until covered by size, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Slot i is occupied when its distance from the head is below the count.
    always_comb begin
        logic [AW-1:0] offs;
        valid_map = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs         = AW'(i) - front_q;
            valid_map[i] = ({1'b0, offs} < size_q);
        end
    end

    assign q.pop_data = is_empty ? '0 : mem_q[front_q];
    assign q.size     = size_q;
    assign q.front    = front_q;
    assign q.valid    = valid_map;
    assign q.full     = is_full;
    assign q.empty    = is_empty;
    assign q.ovf      = ovf_q;
    assign q.udf      = udf_q;

`ifdef CIRC_QUEUE_ALMOST_EN
    assign q.almost_full  = (size_q >= (AW+1)'(AF_LEVEL));
    assign q.almost_empty = (size_q <= (AW+1)'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_circ_queue.sv
// tb/tb_circ_queue.sv - randomized and directed bench for circ_queue against a queue-based model
module tb_circ_queue;
    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    circ_queue_if #(.DEPTH(DEPTH), .DW(DW)) q ();

    circ_queue #(.DEPTH(DEPTH), .DW(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq [$];
    int            mfront = 0;
    logic          movf   = 1'b0;
    logic          mudf   = 1'b0;
    logic          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mfront = 0;
        movf   = 1'b0;
        mudf   = 1'b0;
    endtask

    task automatic model_edge(input logic pu, input logic [DW-1:0] pd, input logic po);
        logic pop_ok, push_ok;
        pop_ok  = po && (mq.size() != 0);
        push_ok = pu && ((mq.size() != DEPTH) || pop_ok);
        if (pop_ok) begin
            void'(mq.pop_front());
            mfront = (mfront + 1) % DEPTH;
        end
        if (push_ok) mq.push_back(pd);
        movf = pu && !push_ok;
        mudf = po && !pop_ok;
    endtask

    task automatic step(input logic pu, input logic [DW-1:0] pd, input logic po);
        @(negedge clk);
        #2;
        q.push      = pu;
        q.push_data = pd;
        q.pop       = po;
        @(posedge clk);
        model_edge(pu, pd, po);
        #1;
        q.push = 1'b0;
        q.pop  = 1'b0;
    endtask

    // Every falling edge: all outputs must match what the model's contents imply.
    always @(negedge clk) begin : cmp
        int n;
        logic [DEPTH-1:0] ev;
        logic [DW-1:0]    epd;
        if (cmp_en) begin
            n   = mq.size();
            ev  = '0;
            for (int k = 0; k < n; k++) ev[(mfront + k) % DEPTH] = 1'b1;
            epd = (n == 0) ? '0 : mq[0];
            chk("size",     32'(q.size),     32'(n));
            chk("front",    32'(q.front),    32'(mfront));
            chk("valid",    32'(q.valid),    32'(ev));
            chk("pop_data", 32'(q.pop_data), 32'(epd));
            chk("full",     32'(q.full),     32'(n == DEPTH));
            chk("empty",    32'(q.empty),    32'(n == 0));
            chk("ovf",      32'(q.ovf),      32'(movf));
            chk("udf",      32'(q.udf),      32'(mudf));
`ifdef CIRC_QUEUE_ALMOST_EN
            chk("almost_full",  32'(q.almost_full),  32'(n >= AF));
            chk("almost_empty", 32'(q.almost_empty), 32'(n <= AE));
`endif
        end
    end

    task automatic random_phase(input int cycles);
        int pp, pq;
        for (int c = 0; c < cycles; c++) begin
            pp = ((c / 64) % 2 == 0) ? 70 : 30;
            pq = 100 - pp;
            step($urandom_range(99) < pp, DW'($urandom), $urandom_range(99) < pq);
        end
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        q.push = 1'b0; q.push_data = '0; q.pop = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_size",  32'(q.size),     32'd0);
        chk("rst_front", 32'(q.front),    32'd0);
        chk("rst_empty", 32'(q.empty),    32'd1);
        chk("rst_full",  32'(q.full),     32'd0);
        chk("rst_valid", 32'(q.valid),    32'd0);
        chk("rst_pdata", 32'(q.pop_data), 32'd0);
        chk("rst_ovf",   32'(q.ovf),      32'd0);
        chk("rst_udf",   32'(q.udf),      32'd0);
`ifdef CIRC_QUEUE_ALMOST_EN
        chk("rst_af", 32'(q.almost_full),  32'd0);
        chk("rst_ae", 32'(q.almost_empty), 32'd1);
`endif
        cmp_en = 1'b1;
        @(negedge clk); #2 rst = 1'b0;

        // Pop on empty -> underflow pulse
        step(1'b0, '0, 1'b1);
        chk("t1_udf",  32'(q.udf),  32'd1);
        chk("t1_size", 32'(q.size), 32'd0);
        step(1'b0, '0, 1'b0);
        chk("t1_udf_clr", 32'(q.udf), 32'd0);

        // Fill 0x01..0x10, then overflow
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
        chk("t2_size",  32'(q.size),  32'd16);
        chk("t2_full",  32'(q.full),  32'd1);
        chk("t2_valid", 32'(q.valid), 32'hFFFF);
        step(1'b1, 8'hEE, 1'b0);
        chk("t2_ovf",   32'(q.ovf),      32'd1);
        chk("t2_size2", 32'(q.size),     32'd16);
        chk("t2_head",  32'(q.pop_data), 32'h01);
        step(1'b0, '0, 1'b0);
        chk("t2_ovf_clr", 32'(q.ovf), 32'd0);

        // Wrap-around
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        chk("t3_front", 32'(q.front), 32'd4);
        chk("t3_size",  32'(q.size),  32'd12);
        chk("t3_valid", 32'(q.valid), 32'hFFF0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + DW'(i), 1'b0);
        chk("t3_valid_full", 32'(q.valid), 32'hFFFF);
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 12) ? DW'(5 + i) : DW'(8'hA0 + i - 12);
            chk("t3_order", 32'(q.pop_data), 32'(exp_d));
            step(1'b0, '0, 1'b1);
        end
        chk("t3_empty", 32'(q.empty), 32'd1);

        // Simultaneous push+pop: empty, mid-level, full
        step(1'b1, 8'h33, 1'b1);
        chk("t4_empty_size", 32'(q.size),     32'd1);
        chk("t4_empty_udf",  32'(q.udf),      32'd1);
        chk("t4_empty_data", 32'(q.pop_data), 32'h33);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + DW'(i), 1'b0);
        chk("t4_pre_front", 32'(q.front), 32'd4);
        step(1'b1, 8'h55, 1'b1);
        chk("t4_mid_size",  32'(q.size),     32'd5);
        chk("t4_mid_front", 32'(q.front),    32'd5);
        chk("t4_mid_head",  32'(q.pop_data), 32'h40);
        for (int i = 0; i < 11; i++) step(1'b1, 8'h60 + DW'(i), 1'b0);
        chk("t4_full", 32'(q.full), 32'd1);
        step(1'b1, 8'h77, 1'b1);
        chk("t4_full_size", 32'(q.size), 32'd16);
        chk("t4_full_ovf",  32'(q.ovf),  32'd0);

        random_phase(1500);

        // Asynchronous reset with size=9, front=7
        @(negedge clk); #2 rst = 1'b1;
        model_reset();
        @(negedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 7; i++) step(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'hC0 + DW'(i), 1'b0);
        chk("t5_pre_size",  32'(q.size),  32'd9);
        chk("t5_pre_front", 32'(q.front), 32'd7);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t5_async_size",  32'(q.size),  32'd0);
        chk("t5_async_front", 32'(q.front), 32'd0);
        chk("t5_async_valid", 32'(q.valid), 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        step(1'b1, 8'h5A, 1'b0);
        chk("t5_post_front", 32'(q.front),    32'd0);
        chk("t5_post_valid", 32'(q.valid),    32'h0001);
        chk("t5_post_data",  32'(q.pop_data), 32'h5A);

`ifdef CIRC_QUEUE_ALMOST_EN
        // Almost thresholds
        for (int i = 0; i < 12; i++) step(1'b1, DW'(i), 1'b0);
        chk("t6_af_13", 32'(q.almost_full), 32'd0);
        step(1'b1, 8'h99, 1'b0);
        chk("t6_af_14", 32'(q.almost_full), 32'd1);
        for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1);
        chk("t6_ae_3", 32'(q.almost_empty), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("t6_ae_2", 32'(q.almost_empty), 32'd1);
`endif

        random_phase(1500);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
